// File: rtl/br_pkg.sv
// Shared types for the branch update unit.
// Update entry layout and redirect FSM states.
package br_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } br_update_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic {
    ST_IDLE,
    ST_REDIR
  } rd_state_e;

endpackage

// File: rtl/br_update_fifo.sv
// Synchronous FIFO of predictor update entries.
// Head is read straight from the entry registers.
module br_update_fifo
  import br_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  br_update_t din,
  output logic       full,
  output logic       empty,
  output br_update_t head
);

  localparam int AW = $clog2(DEPTH);

  br_update_t     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    cnt;
  logic           do_push;
  logic           do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage, needs no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/branch_update_unit.sv
// Branch resolution compare, redirect and
// predictor update queue for the EX stage.
module branch_update_unit
  import br_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ex_valid,
  input  logic [31:0]      i_ex_pc,
  input  logic             i_ex_taken,
  input  logic [31:0]      i_ex_target,
  input  logic             i_ex_prd_taken,
  input  logic [31:0]      i_ex_prd_target,
  output logic             o_ex_ready,
  output logic             o_redirect_valid,
  output logic [31:0]      o_redirect_pc,
  output logic             o_flush,
  output logic             o_br_update_valid,
  output logic [31:0]      o_br_update_pc,
  output logic [31:0]      o_br_update_target,
  output logic             o_br_update_taken,
  output logic [CNT_W-1:0] o_br_count,
  output logic [CNT_W-1:0] o_mispred_count
);

  rd_state_e  state_q;
  rd_state_e  state_d;
  logic       full;
  logic       empty;
  logic       accept;
  logic       mispred;
  logic [31:0] next_pc;
  br_update_t push_entry;
  br_update_t head;

  assign o_ex_ready = !full && !i_rst;
  assign o_redirect_valid = (state_q == ST_REDIR);
  assign o_flush = o_redirect_valid;

  assign accept = i_ex_valid && o_ex_ready
                && !o_redirect_valid;

  assign mispred = (i_ex_taken != i_ex_prd_taken)
                || (i_ex_taken
                    && (i_ex_target != i_ex_prd_target));

  assign next_pc = i_ex_taken ? i_ex_target
                              : i_ex_pc + PC_STEP;

  assign push_entry = '{
    pc:     i_ex_pc,
    target: i_ex_target,
    taken:  i_ex_taken
  };

  br_update_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (accept),
    .pop   (!empty),
    .din   (push_entry),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign o_br_update_valid  = !empty;
  assign o_br_update_pc     = empty ? '0 : head.pc;
  assign o_br_update_target = empty ? '0 : head.target;
  assign o_br_update_taken  = !empty && head.taken;

  // Redirect state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Redirect lasts exactly one cycle
  always_comb begin
    state_d = ST_IDLE;
    unique case (state_q)
      ST_IDLE:  if (accept && mispred) state_d = ST_REDIR;
      ST_REDIR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Capture correct next PC on mispredict
  always_ff @(posedge i_clk) begin
    if (i_rst)                  o_redirect_pc <= '0;
    else if (accept && mispred) o_redirect_pc <= next_pc;
  end

  // Saturating performance counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_br_count      <= '0;
      o_mispred_count <= '0;
    end else if (accept) begin
      if (o_br_count != '1)
        o_br_count <= o_br_count + 1'b1;
      if (mispred && o_mispred_count != '1)
        o_mispred_count <= o_mispred_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_update_unit.sv
// Randomized bench for branch_update_unit
// against a queue-based reference model.
module tb_branch_update_unit;

  localparam int DEPTH = 4;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_ex_valid;
  logic [31:0]      i_ex_pc;
  logic             i_ex_taken;
  logic [31:0]      i_ex_target;
  logic             i_ex_prd_taken;
  logic [31:0]      i_ex_prd_target;
  logic             o_ex_ready;
  logic             o_redirect_valid;
  logic [31:0]      o_redirect_pc;
  logic             o_flush;
  logic             o_br_update_valid;
  logic [31:0]      o_br_update_pc;
  logic [31:0]      o_br_update_target;
  logic             o_br_update_taken;
  logic [CNT_W-1:0] o_br_count;
  logic [CNT_W-1:0] o_mispred_count;

  branch_update_unit #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_ex_valid         (i_ex_valid),
    .i_ex_pc            (i_ex_pc),
    .i_ex_taken         (i_ex_taken),
    .i_ex_target        (i_ex_target),
    .i_ex_prd_taken     (i_ex_prd_taken),
    .i_ex_prd_target    (i_ex_prd_target),
    .o_ex_ready         (o_ex_ready),
    .o_redirect_valid   (o_redirect_valid),
    .o_redirect_pc      (o_redirect_pc),
    .o_flush            (o_flush),
    .o_br_update_valid  (o_br_update_valid),
    .o_br_update_pc     (o_br_update_pc),
    .o_br_update_target (o_br_update_target),
    .o_br_update_taken  (o_br_update_taken),
    .o_br_count         (o_br_count),
    .o_mispred_count    (o_mispred_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tg;
    logic        tk;
  } upd_t;

  upd_t        q[$];
  bit          m_redir;
  logic [31:0] m_rpc;
  int          m_br;
  int          m_mis;
  int          n_vec;
  int          n_err;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic step(input logic        v,
                      input logic [31:0] pc,
                      input logic        tk,
                      input logic [31:0] tg,
                      input logic        ptk,
                      input logic [31:0] ptg,
                      input logic        rst);
    bit acc;
    bit mis;
    upd_t e;
    i_ex_valid      = v;
    i_ex_pc         = pc;
    i_ex_taken      = tk;
    i_ex_target     = tg;
    i_ex_prd_taken  = ptk;
    i_ex_prd_target = ptg;
    i_rst           = rst;
    #1;
    chk("redir", 64'(o_redirect_valid), 64'(m_redir));
    chk("flush", 64'(o_flush), 64'(m_redir));
    if (m_redir) chk("rpc", 64'(o_redirect_pc), 64'(m_rpc));
    chk("ready", 64'(o_ex_ready),
        64'((q.size() < DEPTH) && !rst));
    chk("uvalid", 64'(o_br_update_valid),
        64'(q.size() > 0));
    if (q.size() > 0) begin
      e = q[0];
      chk("upc", 64'(o_br_update_pc), 64'(e.pc));
      chk("utgt", 64'(o_br_update_target), 64'(e.tg));
      chk("utk", 64'(o_br_update_taken), 64'(e.tk));
    end
    chk("brcnt", 64'(o_br_count), 64'(m_br));
    chk("miscnt", 64'(o_mispred_count), 64'(m_mis));
    acc = v && !rst && !m_redir && (q.size() < DEPTH);
    mis = (tk != ptk) || (tk && (tg != ptg));
    if (q.size() > 0) void'(q.pop_front());
    if (rst) begin
      q.delete();
      m_redir = 0;
      m_rpc   = '0;
      m_br    = 0;
      m_mis   = 0;
    end else begin
      m_redir = acc && mis;
      if (acc && mis) m_rpc = tk ? tg : pc + 32'd4;
      if (acc) begin
        e.pc = pc;
        e.tg = tg;
        e.tk = tk;
        q.push_back(e);
        m_br = (m_br < CMAX) ? m_br + 1 : CMAX;
        if (mis) m_mis = (m_mis < CMAX) ? m_mis + 1 : CMAX;
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, '0, 0, '0, 0, '0, 0);
  endtask

  task automatic do_rst();
    step(0, '0, 0, '0, 0, '0, 1);
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] tg;
    logic [31:0] ptg;
    logic        tk;
    logic        ptk;
    n_vec = 0;
    n_err = 0;
    i_rst = 1'b1;
    i_ex_valid = 0;
    i_ex_pc = '0;
    i_ex_taken = 0;
    i_ex_target = '0;
    i_ex_prd_taken = 0;
    i_ex_prd_target = '0;
    m_redir = 0;
    m_rpc = '0;
    m_br = 0;
    m_mis = 0;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    do_rst();
    chk("rst_rpc", 64'(o_redirect_pc), 64'h0);
    chk("rst_upc", 64'(o_br_update_pc), 64'h0);

    step(1, 32'h100, 1, 32'h200, 1, 32'h200, 0);
    chk("t1_redir", 64'(o_redirect_valid), 64'h0);
    chk("t1_uv", 64'(o_br_update_valid), 64'h1);
    chk("t1_upc", 64'(o_br_update_pc), 64'h100);
    chk("t1_utg", 64'(o_br_update_target), 64'h200);
    chk("t1_br", 64'(o_br_count), 64'h1);
    idle(2);

    do_rst();
    step(1, 32'h100, 0, 32'h200, 1, 32'h200, 0);
    chk("t2_redir", 64'(o_redirect_valid), 64'h1);
    chk("t2_rpc", 64'(o_redirect_pc), 64'h104);
    chk("t2_mis", 64'(o_mispred_count), 64'h1);
    step(1, 32'h500, 1, 32'h600, 1, 32'h600, 0);
    chk("t2_sq_br", 64'(o_br_count), 64'h1);
    chk("t2_sq_uv", 64'(o_br_update_valid), 64'h0);
    idle(2);

    do_rst();
    step(1, 32'h100, 1, 32'h300, 1, 32'h200, 0);
    chk("t3_rpc", 64'(o_redirect_pc), 64'h300);
    idle(2);

    step(1, 32'hFFFF_FFFC, 0, 32'h40, 1, 32'h40, 0);
    chk("t4_redir", 64'(o_redirect_valid), 64'h1);
    chk("t4_rpc", 64'(o_redirect_pc), 64'h0);
    idle(2);

    do_rst();
    for (int i = 0; i < 8; i++)
      step(1, 32'h1000 + 32'(i * 8), i[0],
           32'h8000 + 32'(i), i[0],
           32'h8000 + 32'(i), 0);
    idle(3);

    do_rst();
    step(1, 32'h2000, 0, 32'h0, 0, 32'h0, 0);
    step(1, 32'h3000, 1, 32'h3400, 0, 32'h0, 0);
    do_rst();
    chk("t6_redir", 64'(o_redirect_valid), 64'h0);
    chk("t6_uv", 64'(o_br_update_valid), 64'h0);
    chk("t6_upc", 64'(o_br_update_pc), 64'h0);
    chk("t6_rpc", 64'(o_redirect_pc), 64'h0);
    chk("t6_br", 64'(o_br_count), 64'h0);
    idle(4);

    for (int i = 0; i < 800; i++) begin
      pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC
                                         : ($urandom & ~32'h3);
      tg  = $urandom & ~32'h3;
      tk  = 1'($urandom_range(0, 1));
      ptk = ($urandom_range(0, 3) == 0) ? ~tk : tk;
      ptg = ($urandom_range(0, 3) == 0) ? (tg ^ 32'h10) : tg;
      step(($urandom_range(0, 9) < 8), pc, tk, tg, ptk, ptg,
           ($urandom_range(0, 299) == 0));
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
